// File: rtl/hack_ram8.sv
// rtl/hack_ram8.sv - eight-word Hack register file with demux-tree load steering
module hack_ram8 #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              load_in,
  input  logic [ADDR_W-1:0] address_in,
  output logic [WIDTH-1:0]  data_out
);

  localparam int DEPTH = 8;

  generate
    if (ADDR_W != 3) begin : g_bad_addr_w
      $error("hack_ram8: ADDR_W must be 3 (DEPTH fixed at 8)");
    end
  endgenerate

  logic [1:0]       lvl1;
  logic [3:0]       lvl2;
  logic [DEPTH-1:0] load_vec;
  logic [WIDTH-1:0] word_q [DEPTH];
  logic [WIDTH-1:0] word_d [DEPTH];

  // Three cascaded 1x2 demux stages: address bit 2 splits first, bit 0 last.
  always_comb begin
    lvl1     = '0;
    lvl2     = '0;
    load_vec = '0;
    lvl1[1] = load_in &  address_in[2];
    lvl1[0] = load_in & ~address_in[2];
    for (int i = 0; i < 2; i++) begin
      lvl2[2*i+1] = lvl1[i] &  address_in[1];
      lvl2[2*i]   = lvl1[i] & ~address_in[1];
    end
    for (int j = 0; j < 4; j++) begin
      load_vec[2*j+1] = lvl2[j] &  address_in[0];
      load_vec[2*j]   = lvl2[j] & ~address_in[0];
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      word_d[k] = load_vec[k] ? data_in : word_q[k];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < DEPTH; k++) word_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) word_q[k] <= word_d[k];
    end
  end

  // Read has no bypass from data_in: a same-cycle write shows only after the edge.
  assign data_out = word_q[address_in];

  a_addr_known: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    load_in |-> !$isunknown(address_in));

  a_load_onehot0: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    $onehot0(load_vec));

endmodule

// File: tb/tb_hack_ram8.sv
// tb/tb_hack_ram8.sv - table, random and hand-sequence checks for hack_ram8
module tb_hack_ram8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic        ld;
  logic [2:0]  addr;
  logic [15:0] dout;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] model [8];

  typedef struct {
    logic        ld;
    logic [2:0]  a;
    logic [15:0] d;
    logic [15:0] pre;
    logic [15:0] post;
  } vec_t;

  vec_t tbl[$];

  hack_ram8 #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .data_in   (din),
    .load_in   (ld),
    .address_in(addr),
    .data_out  (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic l, input logic [2:0] a, input logic [15:0] d,
                              input logic [15:0] pre, input logic [15:0] post);
    vec_t v;
    v.ld = l; v.a = a; v.d = d; v.pre = pre; v.post = post;
    return v;
  endfunction

  // Drives one cycle; checks before and after the edge against given values.
  task automatic step(input string nm, input logic l, input logic [2:0] a, input logic [15:0] d,
                      input logic [15:0] pre, input logic [15:0] post);
    @(negedge clk);
    ld = l; addr = a; din = d;
    #1 chk({nm, "_pre"}, dout, pre);
    @(posedge clk);
    if (rst_n && l) model[a] = d;
    #1 chk({nm, "_post"}, dout, post);
  endtask

  task automatic step_model(input string nm, input logic l, input logic [2:0] a, input logic [15:0] d);
    logic [15:0] pre, post;
    pre  = model[a];
    post = (rst_n && l) ? d : model[a];
    step(nm, l, a, d, pre, post);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 8; k++) model[k] = 16'h0000;
  endtask

  initial begin
    logic [15:0] v;
    rst_n = 1'b0; ld = 1'b0; addr = 3'd0; din = 16'h0000;
    clear_model();

    for (int k = 0; k < 8; k++) tbl.push_back(mk(1'b0, 3'(k), 16'h0000, 16'h0000, 16'h0000));
    for (int k = 0; k < 8; k++) begin
      v = 16'(16'h1111 * (k + 1));
      tbl.push_back(mk(1'b1, 3'(k), v, 16'h0000, v));
    end
    for (int k = 0; k < 8; k++) begin
      v = 16'(16'h1111 * (k + 1));
      tbl.push_back(mk(1'b0, 3'(k), 16'hDEAD, v, v));
    end
    for (int k = 7; k >= 0; k--) begin
      v = 16'(16'h1111 * (k + 1));
      tbl.push_back(mk(1'b0, 3'(k), 16'hA5A5, v, v));
    end
    tbl.push_back(mk(1'b1, 3'd2, 16'h0001, 16'h3333, 16'h0001));
    tbl.push_back(mk(1'b1, 3'd2, 16'hFFFF, 16'h0001, 16'hFFFF));
    tbl.push_back(mk(1'b1, 3'd6, 16'h1234, 16'h7777, 16'h1234));
    tbl.push_back(mk(1'b1, 3'd6, 16'h5678, 16'h1234, 16'h5678));
    tbl.push_back(mk(1'b1, 3'd7, 16'h0F0F, 16'h8888, 16'h0F0F));
    tbl.push_back(mk(1'b0, 3'd7, 16'hFFFF, 16'h0F0F, 16'h0F0F));
    tbl.push_back(mk(1'b0, 3'd0, 16'hFFFF, 16'h1111, 16'h1111));

    // Reset held for two cycles; output must read zero at every address.
    repeat (2) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      addr = 3'(k);
      #1 chk("reset_sweep", dout, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("tbl%0d", i), tbl[i].ld, tbl[i].a, tbl[i].d, tbl[i].pre, tbl[i].post);

    // Isolation after a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    step("iso_wr", 1'b1, 3'd5, 16'hBEEF, 16'h0000, 16'hBEEF);
    for (int k = 0; k < 8; k++)
      step($sformatf("iso_rd%0d", k), 1'b0, 3'(k), 16'hFFFF, (k == 5) ? 16'hBEEF : 16'h0000,
           (k == 5) ? 16'hBEEF : 16'h0000);

    for (int i = 0; i < 300; i++)
      step_model("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));

    // Async reset between edges after a full fill.
    for (int k = 0; k < 8; k++) step_model("refill", 1'b1, 3'(k), 16'(16'hA000 + k));
    @(negedge clk);
    ld = 1'b1; addr = 3'd3; din = 16'hCAFE;
    #1 chk("pre_async", dout, 16'hA003);
    #1 rst_n = 1'b0;
    clear_model();
    #1 chk("async_clear", dout, 16'h0000);
    @(posedge clk);
    #1 chk("write_in_reset_lost", dout, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      addr = 3'(k); ld = 1'b0;
      #1 chk("post_release_zero", dout, 16'h0000);
    end
    step("first_write", 1'b1, 3'd3, 16'hCAFE, 16'h0000, 16'hCAFE);
    step("other_zero", 1'b0, 3'd4, 16'h1111, 16'h0000, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hack_ram8.md
# hack_ram8

Eight-word, WIDTH-bit register file for the Hack (nand2tetris) memory hierarchy, one level above the elementary logic gates. A 1-to-8 load demultiplexer, built as a tree of 1x2 demux stages, steers `load_in` to exactly one word register. The word at `address_in` is driven to the output through an 8-way read multiplexer. The block is the leaf of the planned RAM64/RAM512 hierarchy and is instantiated eight times by the next level up.

## Interface
- `WIDTH`, default 16: word width in bits; the Hack word is 16.
- `ADDR_W`, default 3: address width. Fixed at 3 for this block, so DEPTH = 8. Any other value is a configuration error and is flagged by an elaboration-time assertion.

- `clk_in`, input, 1: single clock. All state updates occur on the rising edge.
- `rst_n_in`, input, 1: asynchronous, active-low reset. Assertion clears every word immediately. Deassertion is expected synchronous to `clk_in`; that is the integrator's responsibility.
- `data_in`, input, WIDTH: write data.
- `load_in`, input, 1: write enable. When 1, the addressed word captures `data_in` on the rising edge.
- `address_in`, input, ADDR_W: selects the word to write and the word to read. Shared by both.
- `data_out`, output, WIDTH: combinational read of word[`address_in`].

## Operation
- Storage: 8 registers word[0..7], each WIDTH bits.
- Load steering:
  - `load_in` is routed through a 3-level 1x2 demux tree. Level 1 is selected by `address_in[2]`, level 2 by `address_in[1]`, level 3 by `address_in[0]`.
  - The result is the one-hot/zero vector load_vec[7:0]. load_vec[k] = `load_in` AND (`address_in` == k).
  - At most one bit of load_vec is set in any cycle.
- Write: on the rising edge, if load_vec[k] = 1, then word[k] <= `data_in`. All other words hold.
- Read: `data_out` = word[`address_in`]. It is purely combinational from the registers and `address_in`. There is no path from `data_in` to `data_out`.
- Reset: while `rst_n_in` = 0, all word[k] = 0, so `data_out` = 0 for any address. Writes are ignored while reset is asserted.
- No wrap or overflow: every 3-bit address is valid. X/Z on `address_in` with `load_in` = 1 is illegal and is flagged by an assertion in simulation.

## Timing
- Write latency: 1 clock. Data written at edge N is visible on `data_out` after edge N once `address_in` selects that word.
- Read latency: 0 cycles, combinational from `address_in`.
- Read-during-write to the same address, same cycle:
  - Before the edge, `data_out` shows the old value.
  - After the edge, it shows the new value.
  - There is no bypass.
- Back-to-back writes to the same address: the last one wins, one per cycle.
- Back-to-back writes to different addresses: each completes independently, one per cycle.
- Reset asserted mid-operation:
  - All words clear asynchronously, without waiting for an edge.
  - A write coinciding with the reset edge is lost.
  - The first write accepted is on the first rising edge with `rst_n_in` = 1.
- Reset values: `data_out` = 0; all internal words = 0; load_vec = 0 when `load_in` = 0.

## Test plan
- Reset: drive `rst_n_in` = 0 for 2 cycles, then sweep `address_in` 0..7. Required: `data_out` = 0x0000 at every address.
- Fill and read back:
  - Write 0x1111·(k+1) to address k for k = 0..7, one per cycle. Then read 0..7.
  - Required: word[7] = 0x8888, word[0] = 0x1111, and each address returns its own value.
- Isolation: with all words = 0, write 0xBEEF to address 5. Required: address 5 returns 0xBEEF; addresses 0–4, 6 and 7 return 0x0000.
- Read-during-write: hold `address_in` = 2 with word[2] = 0x0001, drive `data_in` = 0xFFFF with `load_in` = 1. Required: `data_out` = 0x0001 before the edge and 0xFFFF after it.
- Load gating: drive `load_in` = 0 with `data_in` = 0xA5A5 for 8 cycles while sweeping addresses. Required: all contents unchanged.
- Async reset mid-stream:
  - After filling all words, pull `rst_n_in` low between edges.
  - Required: `data_out` = 0x0000 within the same cycle, without waiting for an edge, and all words read 0 after release.
  - A write issued on the first edge after release succeeds.
